// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load-data extraction; MEM_WB_INSTRET_EN adds o_instret
module mem_wb_stage #(
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_mem_inst,
    input  logic [31:0] i_mem_pc_add4,
    input  logic [31:0] i_mem_alu_data,
    input  logic [31:0] i_mem_ld_raw,
    input  logic [1:0]  i_mem_wb_sel,
    input  logic        i_mem_rd_wren,
    input  logic        i_mem_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_wb_inst,
    output logic [31:0] o_wb_pc_add4,
    output logic [31:0] o_wb_alu_data,
    output logic [31:0] o_wb_ld_data,
    output logic [1:0]  o_wb_wb_sel,
    output logic        o_wb_rd_wren,
    output logic        o_wb_valid
`ifdef MEM_WB_INSTRET_EN
    ,
    output logic [31:0] o_instret
`endif
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_add4_q, pc_add4_d;
    logic [31:0] alu_data_q, alu_data_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        rd_wren_q, rd_wren_d;
    logic        valid_q, valid_d;

    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign funct3 = i_mem_inst[14:12];
    assign offset = i_mem_alu_data[1:0];

    // Align and extend the raw word before it is registered.
    always_comb begin
        ld_fmt  = i_mem_ld_raw;
        ld_half = offset[1] ? i_mem_ld_raw[31:16] : i_mem_ld_raw[15:0];
        case (offset)
            2'd0:    ld_byte = i_mem_ld_raw[7:0];
            2'd1:    ld_byte = i_mem_ld_raw[15:8];
            2'd2:    ld_byte = i_mem_ld_raw[23:16];
            default: ld_byte = i_mem_ld_raw[31:24];
        endcase
        case (funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = i_mem_ld_raw;
        endcase
    end

    always_comb begin
        inst_d     = inst_q;
        pc_add4_d  = pc_add4_q;
        alu_data_d = alu_data_q;
        ld_data_d  = ld_data_q;
        wb_sel_d   = wb_sel_q;
        rd_wren_d  = rd_wren_q;
        valid_d    = valid_q;
        if (i_flush) begin
            inst_d     = RESET_INST;
            pc_add4_d  = 32'h0;
            alu_data_d = 32'h0;
            ld_data_d  = 32'h0;
            wb_sel_d   = 2'b01;
            rd_wren_d  = 1'b0;
            valid_d    = 1'b0;
        end else if (!i_stall) begin
            inst_d     = i_mem_inst;
            pc_add4_d  = i_mem_pc_add4;
            alu_data_d = i_mem_alu_data;
            ld_data_d  = ld_fmt;
            wb_sel_d   = i_mem_wb_sel;
            rd_wren_d  = i_mem_rd_wren && i_mem_valid && (i_mem_inst[11:7] != 5'd0);
            valid_d    = i_mem_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            inst_q     <= RESET_INST;
            pc_add4_q  <= 32'h0;
            alu_data_q <= 32'h0;
            ld_data_q  <= 32'h0;
            wb_sel_q   <= 2'b01;
            rd_wren_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_add4_q  <= pc_add4_d;
            alu_data_q <= alu_data_d;
            ld_data_q  <= ld_data_d;
            wb_sel_q   <= wb_sel_d;
            rd_wren_q  <= rd_wren_d;
            valid_q    <= valid_d;
        end
    end

    assign o_wb_inst     = inst_q;
    assign o_wb_pc_add4  = pc_add4_q;
    assign o_wb_alu_data = alu_data_q;
    assign o_wb_ld_data  = ld_data_q;
    assign o_wb_wb_sel   = wb_sel_q;
    assign o_wb_rd_wren  = rd_wren_q;
    assign o_wb_valid    = valid_q;

`ifdef MEM_WB_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // Only a normal capture of a real instruction retires it.
    always_comb begin
        instret_d = instret_q;
        if (!i_flush && !i_stall && i_mem_valid)
            instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            instret_q <= 32'h0;
        else
            instret_q <= instret_d;
    end

    assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a behavioural model
module tb_mem_wb_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_mem_inst, i_mem_pc_add4, i_mem_alu_data, i_mem_ld_raw;
    logic [1:0]  i_mem_wb_sel;
    logic        i_mem_rd_wren, i_mem_valid, i_stall, i_flush;
    logic [31:0] o_wb_inst, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data;
    logic [1:0]  o_wb_wb_sel;
    logic        o_wb_rd_wren, o_wb_valid;
`ifdef MEM_WB_INSTRET_EN
    logic [31:0] o_instret;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [31:0] e_inst, e_pc, e_alu, e_ld, e_instret;
    logic [1:0]  e_sel;
    logic        e_wren, e_valid;

    localparam logic [131:0] RESET_BUS = {32'h0000_0013, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0};

    wire [131:0] dut_bus = {o_wb_inst, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data,
                            o_wb_wb_sel, o_wb_rd_wren, o_wb_valid};

    mem_wb_stage dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mem_inst(i_mem_inst), .i_mem_pc_add4(i_mem_pc_add4),
        .i_mem_alu_data(i_mem_alu_data), .i_mem_ld_raw(i_mem_ld_raw),
        .i_mem_wb_sel(i_mem_wb_sel), .i_mem_rd_wren(i_mem_rd_wren),
        .i_mem_valid(i_mem_valid), .i_stall(i_stall), .i_flush(i_flush),
        .o_wb_inst(o_wb_inst), .o_wb_pc_add4(o_wb_pc_add4),
        .o_wb_alu_data(o_wb_alu_data), .o_wb_ld_data(o_wb_ld_data),
        .o_wb_wb_sel(o_wb_wb_sel), .o_wb_rd_wren(o_wb_rd_wren),
        .o_wb_valid(o_wb_valid)
`ifdef MEM_WB_INSTRET_EN
        , .o_instret(o_instret)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_ld(logic [2:0] f3, logic [1:0] off, logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> ((off >= 2'd2) ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic [131:0] exp_bus();
        return {e_inst, e_pc, e_alu, e_ld, e_sel, e_wren, e_valid};
    endfunction

    task automatic drive_rand();
        i_mem_inst     = $urandom;
        i_mem_pc_add4  = $urandom;
        i_mem_alu_data = $urandom;
        i_mem_ld_raw   = $urandom;
        i_mem_wb_sel   = 2'($urandom_range(0, 2));
        i_mem_rd_wren  = 1'($urandom);
        i_mem_valid    = 1'($urandom);
    endtask

    // One rising edge; the model advances from the inputs present at that edge.
    task automatic step();
        @(posedge i_clk);
        if (!i_reset) begin
            e_inst = 32'h13; e_pc = 0; e_alu = 0; e_ld = 0; e_sel = 2'b01;
            e_wren = 0; e_valid = 0; e_instret = 0;
        end else if (i_flush) begin
            e_inst = 32'h13; e_pc = 0; e_alu = 0; e_ld = 0; e_sel = 2'b01;
            e_wren = 0; e_valid = 0;
        end else if (!i_stall) begin
            e_inst  = i_mem_inst;
            e_pc    = i_mem_pc_add4;
            e_alu   = i_mem_alu_data;
            e_ld    = ref_ld(i_mem_inst[14:12], i_mem_alu_data[1:0], i_mem_ld_raw);
            e_sel   = i_mem_wb_sel;
            e_wren  = i_mem_rd_wren && i_mem_valid && (i_mem_inst[11:7] != 0);
            e_valid = i_mem_valid;
            if (i_mem_valid) e_instret = e_instret + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            i_reset = 0; i_stall = 1'($urandom); i_flush = 1'($urandom);
            step();
            compared++;
            if (dut_bus !== RESET_BUS) begin
                mismatched++;
                $display("FAIL reset act=%h exp=%h", dut_bus, RESET_BUS);
            end
        end
        i_reset = 1; i_stall = 0; i_flush = 0;
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3s  [3] = '{3'b000, 3'b101, 3'b001};
        logic [1:0]  offs [3] = '{2'd2, 2'd2, 2'd2};
        logic [31:0] raws [3] = '{32'h1280_3456, 32'hBEEF_0001, 32'hBEEF_0001};
        logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF};
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            i_mem_inst[14:12]   = f3s[k];
            i_mem_alu_data[1:0] = offs[k];
            i_mem_ld_raw        = raws[k];
            step();
            compared++;
            if (o_wb_ld_data !== exps[k]) begin
                mismatched++;
                $display("FAIL load_extract[%0d] act=%h exp=%h", k, o_wb_ld_data, exps[k]);
            end
        end
    endtask

    task automatic test_rd_gating();
        logic [4:0] rds [3] = '{5'd0, 5'd5, 5'd5};
        logic       vls [3] = '{1'b1, 1'b1, 1'b0};
        logic       exw [3] = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            i_mem_rd_wren = 1; i_mem_inst[11:7] = rds[k]; i_mem_valid = vls[k];
            step();
            compared++;
            if (o_wb_rd_wren !== exw[k]) begin
                mismatched++;
                $display("FAIL rd_gating[%0d] act=%b exp=%b", k, o_wb_rd_wren, exw[k]);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [131:0] a_bus;
        drive_rand();
        i_mem_valid = 1;
        step();
        a_bus = exp_bus();
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            step();
            compared++;
            if (dut_bus !== a_bus) begin
                mismatched++;
                $display("FAIL stall_hold[%0d] act=%h exp=%h", k, dut_bus, a_bus);
            end
        end
        drive_rand();
        i_mem_valid = 1; i_flush = 1;
        step();
        compared++;
        if (o_wb_valid !== 1'b0 || o_wb_inst !== 32'h0000_0013 || dut_bus !== RESET_BUS) begin
            mismatched++;
            $display("FAIL stall_flush act=%h exp=%h", dut_bus, RESET_BUS);
        end
        i_stall = 0; i_flush = 0;
    endtask

    task automatic test_reset_mid_stream();
        drive_rand();
        i_mem_valid = 1;
        step();
        i_stall = 1; i_reset = 0;
        drive_rand();
        step();
        compared++;
        if (dut_bus !== RESET_BUS) begin
            mismatched++;
            $display("FAIL reset_mid_stall act=%h exp=%h", dut_bus, RESET_BUS);
        end
        i_reset = 1; i_stall = 0;
        drive_rand();
        step();
        compared++;
        if (dut_bus !== exp_bus()) begin
            mismatched++;
            $display("FAIL resume_after_reset act=%h exp=%h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive_rand();
            i_stall = ($urandom_range(0, 3) == 0);
            i_flush = ($urandom_range(0, 7) == 0);
            i_reset = ($urandom_range(0, 49) != 0);
            step();
            compared++;
            if (dut_bus !== exp_bus()) begin
                mismatched++;
                $display("FAIL random[%0d] act=%h exp=%h", k, dut_bus, exp_bus());
            end
`ifdef MEM_WB_INSTRET_EN
            compared++;
            if (o_instret !== e_instret) begin
                mismatched++;
                $display("FAIL random_instret[%0d] act=%h exp=%h", k, o_instret, e_instret);
            end
`endif
        end
        i_reset = 1; i_stall = 0; i_flush = 0;
    endtask

`ifdef MEM_WB_INSTRET_EN
    task automatic test_instret();
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        e_instret = 32'hFFFF_FFFE;
        drive_rand(); i_mem_valid = 1; i_stall = 1;
        step();
        drive_rand(); i_mem_valid = 1; i_stall = 0; i_flush = 1;
        step();
        compared++;
        if (o_instret !== 32'hFFFF_FFFE) begin
            mismatched++;
            $display("FAIL instret_hold act=%h exp=%h", o_instret, 32'hFFFF_FFFE);
        end
        i_flush = 0;
        for (int k = 0; k < 2; k++) begin
            drive_rand(); i_mem_valid = 1;
            step();
        end
        compared++;
        if (o_instret !== 32'h0) begin
            mismatched++;
            $display("FAIL instret_wrap act=%h exp=%h", o_instret, 32'h0);
        end
    endtask
`endif

    initial begin
        i_reset = 0; i_stall = 0; i_flush = 0;
        drive_rand();
        e_instret = 0;
        test_reset();
        test_load_extract();
        test_rd_gating();
        test_stall_flush();
        test_reset_mid_stream();
        test_random();
`ifdef MEM_WB_INSTRET_EN
        test_instret();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
